// File: rtl/wb_burst_master_if.sv
// Host command/data streams and Wishbone B3 bus of the burst initiator, bundled as one interface.
// The master modport is the initiator's view; the slave modport is the host/bus-slave side.
interface wb_burst_master_if #(
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 16,
    parameter int unsigned LENW = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic            cmd_incr;
    logic [AW-1:0]   cmd_addr;
    logic [LENW-1:0] cmd_len;
    logic            wr_valid;
    logic            wr_ready;
    logic [DW-1:0]   wr_data;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic            done_o;
    logic            err_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW-1:0]   wb_dat_i;
    logic [1:0]      wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_we_o;
    logic            wb_stb_o;
    logic            wb_cyc_o;
    logic            wb_ack_i;
    logic            wb_err_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_incr, cmd_addr, cmd_len, wr_valid, wr_data,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output cmd_ready, wr_ready, rd_valid, rd_data, done_o, err_o,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_we_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_incr, cmd_addr, cmd_len, wr_valid, wr_data,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done_o, err_o,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_we_o, wb_stb_o, wb_cyc_o
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst initiator: turns host read/write commands into CTI-tagged bus cycles
// with per-beat wait states, error termination and a stalled-strobe timeout.
module wb_burst_master #(
    parameter int unsigned AW      = 5,
    parameter int unsigned DW      = 16,
    parameter int unsigned LENW    = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                wb_clk_i,
    input logic                wb_rst_i,
    wb_burst_master_if.master  bus
);
    localparam int unsigned RW = LENW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {StIdle, StBus} state_e;

    state_e          state_q;
    logic            cyc_q, stb_q, we_q, incr_q, done_q, err_q;
    logic [AW-1:0]   adr_q;
    logic [DW-1:0]   dat_q;
    logic [2:0]      cti_q;
    logic [1:0]      sel_q;
    logic [RW-1:0]   remaining_q, fetched_q;
    logic [LENW-1:0] len_q;
    logic [TW-1:0]   tmo_q;

    logic beat_ack, beat_err, timeout, take_wr, finish;

    always_comb begin
        beat_ack = cyc_q & stb_q & bus.wb_ack_i & ~bus.wb_err_i;
        beat_err = cyc_q & stb_q & bus.wb_err_i;
        timeout  = cyc_q & stb_q & ~bus.wb_ack_i & ~bus.wb_err_i & (tmo_q == TW'(TIMEOUT - 1));
        take_wr  = bus.wr_valid & bus.wr_ready;
        finish   = beat_err | timeout | (beat_ack & (remaining_q == RW'(1)));
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.wr_ready  = (state_q == StBus) & we_q & (fetched_q < ({1'b0, len_q} + RW'(1))) &
                           (~stb_q | bus.wb_ack_i);
    assign bus.rd_valid  = beat_ack & ~we_q;
    assign bus.rd_data   = bus.wb_dat_i;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_dat_o  = dat_q;
    assign bus.wb_sel_o  = sel_q;
    assign bus.wb_cti_o  = cti_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_stb_o  = stb_q;
    assign bus.wb_cyc_o  = cyc_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            incr_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            cti_q       <= 3'b000;
            sel_q       <= 2'b00;
            remaining_q <= '0;
            fetched_q   <= '0;
            len_q       <= '0;
            tmo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        state_q     <= StBus;
                        cyc_q       <= 1'b1;
                        we_q        <= bus.cmd_we;
                        incr_q      <= bus.cmd_incr;
                        adr_q       <= bus.cmd_addr;
                        sel_q       <= 2'b11;
                        len_q       <= bus.cmd_len;
                        remaining_q <= RW'(bus.cmd_len) + RW'(1);
                        fetched_q   <= '0;
                        tmo_q       <= '0;
                        cti_q       <= (bus.cmd_len == '0) ? 3'b000 :
                                       (bus.cmd_incr ? 3'b010 : 3'b001);
                    end
                end
                StBus: begin
                    // Only a strobe left hanging without any response ages the timer.
                    if (stb_q & ~bus.wb_ack_i & ~bus.wb_err_i) tmo_q <= tmo_q + TW'(1);
                    else tmo_q <= '0;
                    if (finish) begin
                        state_q <= StIdle;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        cti_q   <= 3'b000;
                        sel_q   <= 2'b00;
                        tmo_q   <= '0;
                        done_q  <= 1'b1;
                        err_q   <= beat_err | timeout;
                    end else begin
                        if (beat_ack) begin
                            remaining_q <= remaining_q - RW'(1);
                            if (incr_q) adr_q <= adr_q + AW'(1);
                            if (remaining_q == RW'(2)) cti_q <= 3'b111;
                        end
                        if (we_q) begin
                            if (take_wr) begin
                                dat_q     <= bus.wr_data;
                                stb_q     <= 1'b1;
                                fetched_q <= fetched_q + RW'(1);
                            end else if (beat_ack) begin
                                stb_q <= 1'b0;
                            end
                        end else begin
                            stb_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// Randomized bench: a reference model queues expected beats and completions per command,
// and an independent monitor pops and compares whatever the bus presents.
module tb_wb_burst_master;
    localparam int unsigned AW = 5, DW = 16, LENW = 8, TMO = 15;

    typedef struct {
        logic [AW-1:0] adr;
        logic [2:0]    cti;
        logic          we;
        logic [DW-1:0] data;
    } beat_t;
    typedef struct {
        logic err;
        logic silent;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_burst_master_if #(.AW(AW), .DW(DW), .LENW(LENW)) bus ();
    wb_burst_master #(.AW(AW), .DW(DW), .LENW(LENW), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus)
    );

    beat_t         exp_beats[$];
    done_t         exp_done[$];
    logic [DW-1:0] wr_q[$];
    logic [DW-1:0] model_mem[32];
    logic [DW-1:0] slave_mem[32];
    int n_checks = 0, n_pass = 0;
    int cycle = 0;
    // Bus-slave and write-stream knobs set per command.
    bit silent = 0;
    int err_beat = -1, wait_lo = 0, wait_hi = 0;
    int gap_beat = -1, gap_len = 0, gap_left = 0, widx = 0;
    bit ignore = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic fail_msg(input string name, input string detail);
        n_checks++;
        $display("FAIL %s: %s", name, detail);
    endtask

    always @(posedge clk) cycle++;

    // Wishbone slave: register file with random wait states, optional error or silence.
    int beat_idx = 0, wait_cnt = 0, wait_tgt = 0;
    always @(negedge clk) begin
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        if (!bus.wb_cyc_o) begin
            beat_idx = 0;
            wait_cnt = 0;
            wait_tgt = $urandom_range(wait_hi, wait_lo);
        end else if (bus.wb_stb_o && !silent) begin
            if (wait_cnt >= wait_tgt) begin
                if (beat_idx == err_beat) bus.wb_err_i = 1'b1;
                else begin
                    bus.wb_ack_i = 1'b1;
                    bus.wb_dat_i = slave_mem[bus.wb_adr_o];
                    if (bus.wb_we_o) slave_mem[bus.wb_adr_o] = bus.wb_dat_o;
                end
                beat_idx++;
                wait_cnt = 0;
                wait_tgt = $urandom_range(wait_hi, wait_lo);
            end else wait_cnt++;
        end
    end

    // Write-data stream driver with an optional gap after word gap_beat.
    initial begin
        bit take;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (gap_left == 0 && wr_q.size() > 0) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = wr_q[0];
            end else bus.wr_valid = 1'b0;
            #1 take = bus.wr_valid && bus.wr_ready;
            @(posedge clk);
            if (take && wr_q.size() > 0) begin
                void'(wr_q.pop_front());
                if (widx == gap_beat) gap_left = gap_len;
                widx++;
            end else if (gap_left > 0) gap_left--;
        end
    end

    // Monitor: compares each acked beat, read word and completion against the queues.
    bit active = 0, stb_prev = 0;
    int stb_rise = 0;
    always @(negedge clk) begin
        beat_t b;
        done_t d;
        #1;
        if (ignore) active = 0;
        else begin
            if (bus.done_o) begin
                active = 0;
                chk("cyc_released", 32'(bus.wb_cyc_o), 0);
                if (exp_done.size() == 0) fail_msg("unexpected_done", "got done_o=1, required 0");
                else begin
                    d = exp_done.pop_front();
                    chk("err_o", 32'(bus.err_o), 32'(d.err));
                    chk("cmd_ready_at_done", 32'(bus.cmd_ready), 1);
                    chk("beats_outstanding", exp_beats.size(), 0);
                    if (d.silent) chk("timeout_cycles", cycle - stb_rise, TMO);
                end
            end else if (active) chk("cyc_held", 32'(bus.wb_cyc_o), 1);
            if (bus.wb_cyc_o) chk("sel", 32'(bus.wb_sel_o), 3);
            if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
                if (exp_beats.size() == 0)
                    fail_msg("unexpected_beat", $sformatf("got beat at adr %0h, required none",
                                                          bus.wb_adr_o));
                else begin
                    b = exp_beats.pop_front();
                    chk("adr", 32'(bus.wb_adr_o), 32'(b.adr));
                    chk("cti", 32'(bus.wb_cti_o), 32'(b.cti));
                    chk("we", 32'(bus.wb_we_o), 32'(b.we));
                    if (b.we) chk("wdata", 32'(bus.wb_dat_o), 32'(b.data));
                    else begin
                        chk("rd_valid", 32'(bus.rd_valid), 1);
                        chk("rd_data", 32'(bus.rd_data), 32'(b.data));
                    end
                end
            end else chk("rd_valid_quiet", 32'(bus.rd_valid), 0);
            if (bus.cmd_valid && bus.cmd_ready) active = 1;
        end
        if (bus.wb_stb_o && !stb_prev) stb_rise = cycle;
        stb_prev = bus.wb_stb_o;
    end

    task automatic drive_cmd(input bit we, input bit incr, input int addr, input int len);
        bit ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_we    = we;
            bus.cmd_incr  = incr;
            bus.cmd_addr  = AW'(addr);
            bus.cmd_len   = LENW'(len);
            #1 ok = bus.cmd_ready;
            @(posedge clk);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (!ok) fail_msg("cmd_accept", "got cmd_ready=0 for 50 cycles, required 1");
    endtask

    // Reference model: beat i hits addr+i (incr) or addr, CTI from position in the burst.
    task automatic run_cmd(input bit we, input bit incr, input int addr, input int len,
                           input int dbase, input int gb, input int gl, input bit sil,
                           input int errb);
        int nb;
        beat_t b;
        done_t d;
        silent = sil; err_beat = errb; gap_beat = gb; gap_len = gl; gap_left = 0; widx = 0;
        nb = sil ? 0 : (errb >= 0 ? errb : len + 1);
        for (int i = 0; i <= len; i++) begin
            b.adr  = AW'((addr + (incr ? i : 0)) % 32);
            b.we   = we;
            b.cti  = (len == 0) ? 3'b000 : (i == len) ? 3'b111 : (incr ? 3'b010 : 3'b001);
            b.data = (dbase > 0) ? DW'(dbase + i) : DW'($urandom);
            if (we) wr_q.push_back(b.data);
            if (i < nb) begin
                if (we) model_mem[b.adr] = b.data;
                else b.data = model_mem[b.adr];
                exp_beats.push_back(b);
            end
        end
        d.err = sil || (errb >= 0);
        d.silent = sil;
        exp_done.push_back(d);
        drive_cmd(we, incr, addr, len);
        for (int c = 0; c < 3000 && exp_done.size() > 0; c++) @(posedge clk);
        if (exp_done.size() > 0) begin
            fail_msg("done_wait", "got no done_o within 3000 cycles, required a done pulse");
            exp_done.delete();
            exp_beats.delete();
        end
        wr_q.delete();
        gap_beat = -1;
        silent = 0;
        err_beat = -1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_incr = 1'b0;
        bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = '0;
        for (int i = 0; i < 32; i++) begin
            slave_mem[i] = DW'($urandom);
            model_mem[i] = slave_mem[i];
        end
        #1 rst = 1'b1;
        #2;
        chk("rst_cyc", 32'(bus.wb_cyc_o), 0);
        chk("rst_stb", 32'(bus.wb_stb_o), 0);
        chk("rst_we", 32'(bus.wb_we_o), 0);
        chk("rst_adr", 32'(bus.wb_adr_o), 0);
        chk("rst_dat", 32'(bus.wb_dat_o), 0);
        chk("rst_cti", 32'(bus.wb_cti_o), 0);
        chk("rst_sel", 32'(bus.wb_sel_o), 0);
        chk("rst_done", 32'(bus.done_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;

        wait_lo = 1; wait_hi = 1;
        run_cmd(0, 0, 5'h03, 0, 0, -1, 0, 0, -1);
        wait_lo = 0; wait_hi = 0;
        run_cmd(1, 1, 5'h1E, 3, 1, -1, 0, 0, -1);
        run_cmd(0, 0, 5'h10, 7, 0, -1, 0, 0, -1);
        run_cmd(1, 1, 5'h08, 3, 0, 1, 2, 0, -1);
        run_cmd(0, 1, 5'h04, 2, 0, -1, 0, 1, -1);
        run_cmd(1, 0, 5'h07, 2, 0, -1, 0, 1, -1);
        wait_hi = 2;
        run_cmd(0, 1, 5'h0A, 5, 0, -1, 0, 0, 2);
        run_cmd(1, 1, 5'h14, 4, 0, -1, 0, 0, 1);

        // Reset in the middle of a long read burst: bus drops at once, no completion.
        ignore = 1; wait_lo = 1; wait_hi = 2;
        drive_cmd(0, 0, 5'h02, 30);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #3;
        chk("cyc_before_reset", 32'(bus.wb_cyc_o), 1);
        rst = 1'b1;
        #1;
        chk("reset_cyc_async", 32'(bus.wb_cyc_o), 0);
        chk("reset_stb_async", 32'(bus.wb_stb_o), 0);
        @(negedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 chk("no_done_after_reset", 32'(bus.done_o), 0);
        end
        exp_beats.delete(); exp_done.delete(); wr_q.delete();
        ignore = 0;
        run_cmd(0, 1, 5'h1C, 5, 0, -1, 0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            int len, errb;
            len = $urandom_range(9, 0);
            errb = ($urandom_range(7, 0) == 0) ? $urandom_range(len, 0) : -1;
            wait_lo = 0; wait_hi = $urandom_range(2, 0);
            run_cmd(1'($urandom), 1'($urandom), $urandom_range(31, 0), len, 0,
                    $urandom_range(len, 0), $urandom_range(2, 0), 0, errb);
        end
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no end of test by 600000, required completion");
        $fatal(1);
    end
endmodule
